// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache miss fill engine.
package cache_pkg;

   localparam int unsigned ADDR_WIDTH     = 16;
   localparam int unsigned BLOCK_WORDS    = 8;
   localparam int unsigned WORD_IDX_W     = 3;
   localparam int unsigned BLOCK_OFFSET_W = WORD_IDX_W + 1;
   // Fill counters need one extra bit so they can hold BLOCK_WORDS itself.
   localparam int unsigned CNT_W          = WORD_IDX_W + 1;

   typedef enum logic {
      StIdle = 1'b0,
      StFill = 1'b1
   } fill_state_e;

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear, enable and saturation at a fixed maximum.
module fill_counter
   import cache_pkg::*;
#(
   parameter int unsigned Width  = CNT_W,
   parameter int unsigned MaxVal = BLOCK_WORDS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [Width-2:0] idx,
   output logic             at_max
);

   logic [Width-1:0] count_q;

   assign at_max = (count_q == Width'(MaxVal));
   assign idx    = count_q[Width-2:0];

   // Count enabled events; hold once the maximum is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && !at_max) begin
         count_q <= count_q + Width'(1);
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: issues one block of pipelined word reads and streams the
// returned words into the data array, finishing with a single tag write.
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   output logic                  fsm_busy,
   output logic                  memory_en,
   output logic [ADDR_WIDTH-1:0] memory_address,
   input  logic                  memory_data_valid,
   input  logic [15:0]           memory_data,
   output logic                  write_data_array,
   output logic [WORD_IDX_W-1:0] cache_word_sel,
   output logic [15:0]           cache_data,
   output logic                  write_tag_array
);

   fill_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] blk_base_q;

   logic                  in_fill, accept;
   logic                  issue_en, issue_done;
   logic                  ret_en, ret_last, fill_done;
   logic [WORD_IDX_W-1:0] issue_idx, ret_idx;

   assign in_fill   = (state_q == StFill);
   assign accept    = (state_q == StIdle) && miss_detected;
   assign issue_en  = in_fill && !issue_done;
   assign ret_en    = in_fill && memory_data_valid;
   assign fill_done = ret_en && ret_last;

   fill_counter #(
      .Width  (CNT_W),
      .MaxVal (BLOCK_WORDS)
   ) u_issue_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .en     (issue_en),
      .idx    (issue_idx),
      .at_max (issue_done)
   );

   // Return counter parks on the last word index; the fill ends on that word anyway.
   fill_counter #(
      .Width  (CNT_W),
      .MaxVal (BLOCK_WORDS - 1)
   ) u_ret_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .en     (ret_en),
      .idx    (ret_idx),
      .at_max (ret_last)
   );

   // Latch the block-aligned base address when a miss is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_base_q <= '0;
      end else if (accept) begin
         blk_base_q <= {miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a miss starts a fill; the last returned word ends it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (miss_detected) state_d = StFill;
         StFill: if (fill_done)     state_d = StIdle;
         default:                   state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and counters; everything is quiet outside a fill.
   always_comb begin
      fsm_busy         = 1'b0;
      memory_en        = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      cache_word_sel   = '0;
      cache_data       = '0;
      write_tag_array  = 1'b0;
      if (in_fill) begin
         fsm_busy         = 1'b1;
         memory_en        = issue_en;
         memory_address   = blk_base_q |
                            {{(ADDR_WIDTH - BLOCK_OFFSET_W){1'b0}}, issue_idx, 1'b0};
         write_data_array = memory_data_valid;
         cache_word_sel   = ret_idx;
         cache_data       = memory_data;
         write_tag_array  = fill_done;
      end
   end

endmodule
